// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package updown_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // A 1-bit register is kept even for PRESCALE=1 so the prescaler never has zero width.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Divides the enable stream: emits one step per PRESCALE enabled cycles.
module cnt_prescaler
  import updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int               PW   = clog2_safe(PRESCALE);
  localparam logic [PW-1:0]    LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign step = en & (pre_q == LAST);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pre_d = pre_q;
    if (en) begin
      pre_d = step ? '0 : pre_q + PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised synchronous up/down modulo counter with prescaler, load,
// wrap/saturate boundary handling and cascade outputs.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = 0,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             carry,
  output logic             wrap,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("updown_counter_mod: MODULUS must be in 2..2**WIDTH");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_saturate
    $error("updown_counter_mod: SATURATE must be 0 or 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_counter_mod: PRESCALE must be at least 1");
  end

  // One extra bit lets MODULUS == 2**WIDTH be represented in the comparisons.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             step;
  logic             at_max, at_zero, load_ok;

  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr | load),
    .en   (en),
    .step (step)
  );

  assign at_max  = ({1'b0, cnt_q} == MAX_X);
  assign at_zero = (cnt_q == '0);
  assign load_ok = ({1'b0, load_val} < MOD_X);

  assign tc    = (up_dn == DIR_UP) ? at_max : at_zero;
  assign carry = tc & step;

  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      if (load_ok) begin
        cnt_d = load_val;
      end else begin
        cnt_d      = MAX_W;
        load_err_d = 1'b1;
      end
    end else if (step) begin
      if (tc) begin
        wrap_d = 1'b1;
        if (SATURATE == MODE_WRAP) begin
          cnt_d = (up_dn == DIR_UP) ? '0 : MAX_W;
        end
      end else begin
        cnt_d = (up_dn == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt      = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: table vectors, directed corner sequences and a
// randomized run against an arithmetic reference model.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clr, load;
  logic [3:0] load_val;

  logic [3:0] cnt_v [4];
  logic       tc_v [4], carry_v [4], wrap_v [4], lerr_v [4];

  logic [3:0] c0_cnt, c1_cnt;
  logic       c0_tc, c0_carry, c0_wrap, c0_lerr;
  logic       c1_tc, c1_carry, c1_wrap, c1_lerr;

  int checks = 0;
  int errors = 0;

  // DUT 0: M10 wrap, 1: M16 wrap, 2: M10 saturate, 3: M10 prescale 3
  function automatic int cfg_mod(input int g);
    return (g == 1) ? 16 : 10;
  endfunction
  function automatic int cfg_sat(input int g);
    return (g == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_pre(input int g);
    return (g == 3) ? 3 : 1;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    updown_counter_mod #(
      .WIDTH    (4),
      .MODULUS  (cfg_mod(g)),
      .SATURATE (cfg_sat(g)),
      .PRESCALE (cfg_pre(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_dn    (up_dn),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .cnt      (cnt_v[g]),
      .tc       (tc_v[g]),
      .carry    (carry_v[g]),
      .wrap     (wrap_v[g]),
      .load_err (lerr_v[g])
    );
  end

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cnt(c0_cnt), .tc(c0_tc), .carry(c0_carry),
    .wrap(c0_wrap), .load_err(c0_lerr)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c1 (
    .clk(clk), .rst(rst), .en(c0_carry), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cnt(c1_cnt), .tc(c1_tc), .carry(c1_carry),
    .wrap(c1_wrap), .load_err(c1_lerr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic e, input logic u, input logic c,
                        input logic l, input logic [3:0] lv);
    rst = r; en = e; up_dn = u; clr = c; load = l; load_val = lv;
  endtask

  // Reference model: plain modular arithmetic on integers.
  int m_cnt [4], m_pre [4], m_wrap [4], m_lerr [4];

  task automatic model_edge(input int g);
    int m, p, nxt;
    m = cfg_mod(g);
    p = cfg_pre(g);
    if (rst || clr) begin
      m_cnt[g] = 0; m_pre[g] = 0; m_wrap[g] = 0; m_lerr[g] = 0;
    end else if (load) begin
      m_pre[g]  = 0;
      m_wrap[g] = 0;
      m_lerr[g] = (int'(load_val) >= m) ? 1 : 0;
      m_cnt[g]  = m_lerr[g] ? m - 1 : int'(load_val);
    end else begin
      m_wrap[g] = 0;
      m_lerr[g] = 0;
      if (en) begin
        m_pre[g] = (m_pre[g] + 1) % p;
        if (m_pre[g] == 0) begin
          nxt = m_cnt[g] + (up_dn ? 1 : -1);
          if (nxt < 0 || nxt >= m) begin
            m_wrap[g] = 1;
            if (cfg_sat(g) == 0) m_cnt[g] = (nxt + m) % m;
          end else begin
            m_cnt[g] = nxt;
          end
        end
      end
    end
  endtask

  typedef struct {
    logic       rst, en, up, clr, load;
    logic [3:0] lv;
    int         exp_cnt;
    logic       exp_wrap, exp_lerr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic u, input logic c,
                              input logic l, input logic [3:0] lv, input int ec,
                              input logic ew, input logic el);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.clr = c; v.load = l; v.lv = lv;
    v.exp_cnt = ec; v.exp_wrap = ew; v.exp_lerr = el;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    int exp_tc, exp_step;
    int pre_exp [7];

    vecs[0]  = mk(1, 0, 0, 0, 0, 4'd0,  0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 4'd12, 9, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 4'd0,  9, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 1, 4'd7,  7, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 1, 4'd12, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 4'd15, 9, 0, 1);
    vecs[6]  = mk(1, 1, 1, 1, 1, 4'd12, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 4'd0,  9, 1, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 4'd0,  8, 0, 0);
    vecs[9]  = mk(0, 1, 1, 0, 1, 4'd3,  3, 0, 0);
    vecs[10] = mk(0, 1, 1, 0, 0, 4'd0,  4, 0, 0);
    vecs[11] = mk(0, 1, 1, 1, 0, 4'd0,  0, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 1, 4'd9,  9, 0, 0);
    vecs[13] = mk(0, 1, 1, 0, 0, 4'd0,  0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 4'd10, 9, 0, 1);

    set_in(0, 0, 0, 0, 0, 4'd0);
    tick();

    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].load, vecs[i].lv);
      tick();
      check($sformatf("vec%0d cnt", i),  cnt_v[0],  vecs[i].exp_cnt);
      check($sformatf("vec%0d wrap", i), wrap_v[0], vecs[i].exp_wrap);
      check($sformatf("vec%0d lerr", i), lerr_v[0], vecs[i].exp_lerr);
    end

    // Reset then count up through the modulus-10 wrap.
    set_in(1, 0, 0, 0, 0, 4'd0);
    tick();
    set_in(0, 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("up%0d cnt", i),   cnt_v[0],   i % 10);
      check($sformatf("up%0d tc", i),    tc_v[0],    (i % 10) == 9);
      check($sformatf("up%0d carry", i), carry_v[0], (i % 10) == 9);
      check($sformatf("up%0d wrap", i),  wrap_v[0],  i == 10);
      tick();
    end

    // Modulus-16 down count from reset wraps to 15.
    set_in(1, 0, 0, 0, 0, 4'd0);
    tick();
    set_in(0, 1, 0, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("dn%0d cnt", i),  cnt_v[1],  (16 - i) % 16);
      check($sformatf("dn%0d tc", i),   tc_v[1],   i == 0);
      check($sformatf("dn%0d wrap", i), wrap_v[1], i == 1);
      tick();
    end

    // Saturating counter holds at both ends.
    set_in(1, 0, 0, 0, 0, 4'd0);
    tick();
    set_in(0, 0, 0, 0, 1, 4'd8);
    tick();
    set_in(0, 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("satup%0d cnt", i),  cnt_v[2],  (8 + i > 9) ? 9 : 8 + i);
      check($sformatf("satup%0d wrap", i), wrap_v[2], i >= 2);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 4'd1);
    tick();
    set_in(0, 1, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("satdn%0d cnt", i),  cnt_v[2],  (i == 0) ? 1 : 0);
      check($sformatf("satdn%0d wrap", i), wrap_v[2], i == 2);
      tick();
    end

    // Prescale 3 with a gap in the enable stream, then a mid-prescale load.
    set_in(1, 0, 0, 0, 0, 4'd0);
    tick();
    pre_exp = '{0, 0, 0, 1, 1, 1, 2};
    for (int i = 0; i < 7; i++) begin
      set_in(0, (i != 2), 1, 0, 0, 4'd0);
      tick();
      check($sformatf("pre%0d cnt", i), cnt_v[3], pre_exp[i]);
    end
    set_in(0, 1, 1, 0, 0, 4'd0);
    tick();
    check("pre_mid cnt", cnt_v[3], 2);
    set_in(0, 1, 1, 0, 1, 4'd5);
    tick();
    check("pre_load cnt", cnt_v[3], 5);
    set_in(0, 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pre_restart%0d cnt", i), cnt_v[3], (i == 2) ? 6 : 5);
    end

    // Two-stage decimal cascade.
    set_in(1, 0, 0, 0, 0, 4'd0);
    tick();
    set_in(0, 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 25; i++) begin
      #1;
      check($sformatf("casc%0d value", i), 32'(c1_cnt) * 10 + 32'(c0_cnt), i);
      tick();
    end

    // Randomized run against the reference model.
    set_in(1, 0, 0, 0, 0, 4'd0);
    for (int g = 0; g < 4; g++) model_edge(g);
    tick();
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(49) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
             ($urandom_range(15) == 0), ($urandom_range(9) == 0), 4'($urandom_range(15)));
      #1;
      for (int g = 0; g < 4; g++) begin
        exp_tc   = up_dn ? (m_cnt[g] == cfg_mod(g) - 1) : (m_cnt[g] == 0);
        exp_step = en && (m_pre[g] == cfg_pre(g) - 1);
        check($sformatf("rnd%0d dut%0d tc", n, g),    tc_v[g],    exp_tc);
        check($sformatf("rnd%0d dut%0d carry", n, g), carry_v[g], exp_tc & exp_step);
        model_edge(g);
      end
      tick();
      for (int g = 0; g < 4; g++) begin
        check($sformatf("rnd%0d dut%0d cnt", n, g),  cnt_v[g],  m_cnt[g]);
        check($sformatf("rnd%0d dut%0d wrap", n, g), wrap_v[g], m_wrap[g]);
        check($sformatf("rnd%0d dut%0d lerr", n, g), lerr_v[g], m_lerr[g]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised synchronous up/down modulo counter. It is the next generation of the team's 4-bit ripple T-flip-flop down counter.
- All state is on a single clock; there are no derived clocks.
- Adds the following over the ripple counter:
  - arbitrary width and modulus
  - direction control
  - parallel load
  - wrap or saturate mode
  - clock-enable prescaler
  - terminal-count and cascade outputs
- Used as a timer/event counter and as a cascadable stage for wider counters.

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MODULUS, 16: count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0: 0 = wrap at the boundary; 1 = hold at the boundary.
- PRESCALE, 1: number of enabled cycles per count step; 1 = step on every enabled cycle.

Ports:
- clk, input, 1: sole clock; all logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: count enable; also serves as the cascade input (connect to the previous stage's carry).
- up_dn, input, 1: direction; 1 = count up, 0 = count down.
- clr, input, 1: synchronous clear to 0.
- load, input, 1: synchronous parallel load.
- load_val, input, WIDTH: value captured when load is asserted.
- cnt, output, WIDTH: current count (registered).
- tc, output, 1: terminal count (combinational from state and inputs).
- carry, output, 1: cascade output; equals tc & step.
- wrap, output, 1: registered one-cycle pulse when the counter wrapped or saturated.
- load_err, output, 1: registered one-cycle pulse when load_val was out of range.

Behaviour:
- Reset (rst=1 at a clock edge): cnt=0, prescaler=0, wrap=0, load_err=0. rst overrides every other input.
- Priority per edge: rst > clr > load > count step.
- clr: cnt=0, prescaler=0, wrap=0. load is ignored in the same cycle.
- load:
  - If load_val < MODULUS: cnt=load_val and load_err=0.
  - Otherwise: cnt=MODULUS-1 and load_err=1 for exactly one cycle.
  - In both cases the prescaler is cleared to 0.
  - en is ignored in a load cycle.
- Prescaler:
  - Internal counter 0..PRESCALE-1, advances only when en=1.
  - step = en & (prescaler == PRESCALE-1).
  - The prescaler wraps to 0 on step.
  - When PRESCALE=1, step = en.
- tc:
  - Asserted when up_dn=1 and cnt == MODULUS-1.
  - Asserted when up_dn=0 and cnt == 0.
  - Independent of en.
- Count on step (no rst/clr/load):
  - Up, cnt < MODULUS-1: cnt+1.
  - Down, cnt > 0: cnt-1.
  - Up at MODULUS-1: next value is 0 when SATURATE=0, or stays MODULUS-1 when SATURATE=1.
  - Down at 0: next value is MODULUS-1 when SATURATE=0, or stays 0 when SATURATE=1.
  - In both boundary cases wrap=1 on the following cycle.
- wrap: high for exactly one cycle after any boundary step, in either mode. Otherwise 0.
- up_dn may change on any cycle. The new direction applies to that same edge's step and to tc immediately.
- en=0: cnt and the prescaler hold; carry=0.
- Arithmetic: an internal width of WIDTH+1 is used for comparisons. When MODULUS == 2**WIDTH, natural overflow must match the explicit wrap.
- Outputs never take X after the first reset. Before the first reset they are undefined.

Decomposition:
- Package updown_counter_pkg:
  - Direction constants DIR_UP=1'b1 and DIR_DN=1'b0.
  - Boundary-mode constants MODE_WRAP=0 and MODE_SAT=1.
  - Function clog2_safe for the prescaler width; returns 1 when PRESCALE=1.
- One sub-module: cnt_prescaler.
  - Parameter PRESCALE.
  - Ports: clk, rst, clr (from clr|load), en, step.
  - A single instance inside updown_counter_mod.
- Main module holds the count register, tc/carry logic, wrap/load_err pulses, and the parameter-legality checks (elaboration-time $error).

Test Plan:
- Reset and wrap up: WIDTH=4, MODULUS=10, rst pulse, then en=1, up_dn=1 for 12 cycles.
  - Required: cnt 0,1,...,9,0,1.
  - tc high while cnt=9.
  - carry high on that same cycle.
  - wrap pulses on the cycle cnt shows 0.
- Down wrap from reset (legacy behaviour): MODULUS=16, up_dn=0, en=1.
  - Required: cnt 0,15,14,13.
  - tc high at 0; wrap pulses when cnt=15.
- Saturate: SATURATE=1, MODULUS=10, load 8, count up 4 steps.
  - Required: cnt 8,9,9,9.
  - wrap pulses once per saturated step.
  - Down from 1 gives 0,0.
- Load and priority:
  - load_val=12 with MODULUS=10: cnt=9, load_err=1 for one cycle.
  - clr and load in the same cycle: cnt=0, load_err=0.
  - rst together with clr/load: everything reset.
- Prescaler: PRESCALE=3, en toggles 1,1,0,1,1,1,1.
  - Required: cnt increments only after the 3rd and 6th enabled cycles, i.e. cnt=1 then 2.
  - Load mid-prescale restarts the 3-cycle count.
- Cascade: two instances, WIDTH=4, MODULUS=10, stage1.en = stage0.carry, run 25 steps up.
  - Required: {stage1,stage0} reads decimal 00..24.
  - stage1 increments only on the 9->0 transition of stage0.
